// File: rtl/uart_debug_bridge.sv
// UART debug responder: W/R/H/G command frames to a single-word memory bus.
// Optional trailing XOR checksum on W/R frames: `define DEBUG_BRIDGE_CHECKSUM_EN.
module uart_debug_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_rx_data,
  input  logic        in_rx_valid,
  output logic        out_rx_ack,
  output logic        out_tx_en,
  output logic [7:0]  out_tx_data,
  input  logic        in_tx_active,
  input  logic        in_tx_done,
  output logic [31:0] out_mem_address,
  output logic        out_mem_write_en,
  output logic [31:0] out_mem_write_data,
  input  logic [31:0] in_mem_read_data,
  output logic        out_cpu_hold,
  output logic        out_busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LW = $clog2(READ_LATENCY + 1) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    RX_ADDR,
    RX_DATA,
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
    RX_CSUM,
`endif
    MEM_WRITE,
    MEM_READ,
    TX_LOAD,
    TX_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [1:0]    guard_q, guard_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [31:0]   rsp_q, rsp_d;
  logic [2:0]    nrsp_q, nrsp_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [7:0]    txd_q, txd_d;
  logic          txen_q, txen_d;
  logic          ack_q, ack_d;
  logic          hold_q, hold_d;
  logic          is_wr_q, is_wr_d;
  logic          rx_st;
  logic          cap;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  always_comb begin
    rx_st = (state_q == IDLE) || (state_q == RX_ADDR) ||
            (state_q == RX_DATA);
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
    rx_st = rx_st || (state_q == RX_CSUM);
`endif
    cap = in_rx_valid && (guard_q == 2'd0) && rx_st;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    maddr_d = maddr_q;
    rsp_d   = rsp_q;
    nrsp_d  = nrsp_q;
    tmo_d   = tmo_q;
    lat_d   = lat_q;
    txd_d   = txd_q;
    hold_d  = hold_q;
    is_wr_d = is_wr_q;
    txen_d  = 1'b0;
    ack_d   = 1'b0;
    guard_d = (guard_q == 2'd0) ? 2'd0 : guard_q - 2'd1;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    // Captured byte: ack next cycle, then ignore rx_valid for two cycles
    if (cap) begin
      ack_d   = 1'b1;
      guard_d = 2'd2;
      tmo_d   = '0;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
      csum_d  = csum_q ^ in_rx_data;
`endif
    end

    case (state_q)
      IDLE: begin
        if (cap) begin
          nrsp_d = 3'd1;
          case (in_rx_data)
            CMD_W: begin
              is_wr_d = 1'b1;
              state_d = RX_ADDR;
            end
            CMD_R: begin
              is_wr_d = 1'b0;
              state_d = RX_ADDR;
            end
            CMD_H: begin
              hold_d  = 1'b1;
              rsp_d   = {24'h0, ACK};
              state_d = TX_LOAD;
            end
            CMD_G: begin
              hold_d  = 1'b0;
              rsp_d   = {24'h0, ACK};
              state_d = TX_LOAD;
            end
            default: begin
              rsp_d   = {24'h0, NAK};
              state_d = TX_LOAD;
            end
          endcase
        end
      end
      RX_ADDR: begin
        if (cap) begin
          addr_d = {in_rx_data, addr_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            maddr_d = addr_d;
            lat_d   = '0;
            if (is_wr_q) state_d = RX_DATA;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
            else         state_d = RX_CSUM;
`else
            else         state_d = MEM_READ;
`endif
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RX_DATA: begin
        if (cap) begin
          data_d = {in_rx_data, data_q[31:8]};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
            state_d = RX_CSUM;
`else
            state_d = MEM_WRITE;
`endif
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
      RX_CSUM: begin
        if (cap) begin
          if (in_rx_data == csum_q) begin
            state_d = is_wr_q ? MEM_WRITE : MEM_READ;
          end else begin
            rsp_d   = {24'h0, NAK};
            nrsp_d  = 3'd1;
            state_d = TX_LOAD;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
`endif
      MEM_WRITE: begin
        rsp_d   = {24'h0, ACK};
        nrsp_d  = 3'd1;
        state_d = TX_LOAD;
      end
      MEM_READ: begin
        // Address has been stable since entry; sample once latency elapsed
        if (lat_q == LAT_LAST) begin
          rsp_d   = in_mem_read_data;
          nrsp_d  = 3'd4;
          state_d = TX_LOAD;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      TX_LOAD: begin
        if (!in_tx_active) begin
          txen_d  = 1'b1;
          txd_d   = rsp_q[7:0];
          state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (in_tx_done) begin
          rsp_d  = {8'h0, rsp_q[31:8]};
          nrsp_d = nrsp_q - 3'd1;
          state_d = (nrsp_q == 3'd1) ? IDLE : TX_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      cnt_d  = '0;
      addr_d = '0;
      data_d = '0;
      tmo_d  = '0;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
      csum_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      guard_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      maddr_q <= '0;
      rsp_q   <= '0;
      nrsp_q  <= '0;
      tmo_q   <= '0;
      lat_q   <= '0;
      txd_q   <= '0;
      txen_q  <= 1'b0;
      ack_q   <= 1'b0;
      hold_q  <= 1'b0;
      is_wr_q <= 1'b0;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      maddr_q <= maddr_d;
      rsp_q   <= rsp_d;
      nrsp_q  <= nrsp_d;
      tmo_q   <= tmo_d;
      lat_q   <= lat_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      ack_q   <= ack_d;
      hold_q  <= hold_d;
      is_wr_q <= is_wr_d;
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign out_rx_ack         = ack_q;
  assign out_tx_en          = txen_q;
  assign out_tx_data        = txd_q;
  assign out_mem_address    = maddr_q;
  assign out_mem_write_en   = (state_q == MEM_WRITE);
  assign out_mem_write_data = data_q;
  assign out_cpu_hold       = hold_q;
  assign out_busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_debug_bridge.sv
// Directed bench for uart_debug_bridge with UART TX and memory models.
// Define DEBUG_BRIDGE_CHECKSUM_EN to exercise the checksum build.
module tb_uart_debug_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_rx_data;
  logic        in_rx_valid;
  logic        out_rx_ack;
  logic        out_tx_en;
  logic [7:0]  out_tx_data;
  logic        in_tx_active;
  logic        in_tx_done;
  logic [31:0] out_mem_address;
  logic        out_mem_write_en;
  logic [31:0] out_mem_write_data;
  logic [31:0] in_mem_read_data;
  logic        out_cpu_hold;
  logic        out_busy;

  always #5 clk = ~clk;

  uart_debug_bridge #(
    .TIMEOUT_CYCLES(100),
    .READ_LATENCY  (1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_rx_data        (in_rx_data),
    .in_rx_valid       (in_rx_valid),
    .out_rx_ack        (out_rx_ack),
    .out_tx_en         (out_tx_en),
    .out_tx_data       (out_tx_data),
    .in_tx_active      (in_tx_active),
    .in_tx_done        (in_tx_done),
    .out_mem_address   (out_mem_address),
    .out_mem_write_en  (out_mem_write_en),
    .out_mem_write_data(out_mem_write_data),
    .in_mem_read_data  (in_mem_read_data),
    .out_cpu_hold      (out_cpu_hold),
    .out_busy          (out_busy)
  );

`ifdef DEBUG_BRIDGE_CHECKSUM_EN
  localparam int W_ACKS = 10;
`else
  localparam int W_ACKS = 9;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int ack_cnt = 0, ack_cyc = 0;
  int wr_cnt = 0, wr_cyc = -1;
  logic [31:0] wr_a, wr_d;
  logic [7:0]  txq[$];
  int tx_viol = 0;
  logic tx_busy, tx_out;
  logic [7:0] tx_byte;
  int tx_cnt;

  assign in_tx_active = tx_busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    in_mem_read_data <= (out_mem_address == 32'h10) ?
                        32'hDEADBEEF : 32'h0BAD0BAD;

  always @(posedge clk) begin
    if (!reset) begin
      if (out_rx_ack) begin
        ack_cnt++;
        ack_cyc = cyc;
      end
      if (out_mem_write_en) begin
        wr_cnt++;
        wr_cyc = cyc;
        wr_a = out_mem_address;
        wr_d = out_mem_write_data;
      end
    end
  end

  // Transmitter: busy for a few cycles per byte, then a done pulse
  always @(posedge clk) begin
    if (reset) begin
      tx_busy    <= 1'b0;
      tx_out     <= 1'b0;
      in_tx_done <= 1'b0;
      tx_cnt     <= 0;
      tx_byte    <= 8'h0;
    end else begin
      in_tx_done <= 1'b0;
      if (tx_out && !out_tx_en && out_tx_data !== tx_byte) tx_viol++;
      if (in_tx_done) tx_out <= 1'b0;
      if (out_tx_en) begin
        if (tx_out && !in_tx_done) tx_viol++;
        txq.push_back(out_tx_data);
        tx_byte <= out_tx_data;
        tx_out  <= 1'b1;
        tx_busy <= 1'b1;
        tx_cnt  <= 4;
      end else if (tx_busy) begin
        if (tx_cnt == 0) begin
          tx_busy    <= 1'b0;
          in_tx_done <= 1'b1;
        end else begin
          tx_cnt <= tx_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    @(negedge clk);
    in_rx_valid = 1'b1;
    in_rx_data  = b;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_rx_ack) begin
        got = 1'b1;
        break;
      end
    end
    in_rx_valid = 1'b0;
    if (!got) check("rx_ack_seen", {31'b0, got}, 32'd1);
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!out_busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) check("idle_reached", {31'b0, idle}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a,
                            input logic [31:0] d, input bit bad);
    logic [7:0] cs;
    cs = cmd;
    send_byte(cmd);
    for (int i = 0; i < 4; i++) begin
      send_byte(a[8*i +: 8]);
      cs = cs ^ a[8*i +: 8];
    end
    if (cmd == 8'h57) begin
      for (int i = 0; i < 4; i++) begin
        send_byte(d[8*i +: 8]);
        cs = cs ^ d[8*i +: 8];
      end
    end
`ifdef DEBUG_BRIDGE_CHECKSUM_EN
    send_byte(bad ? (cs ^ 8'h5A) : cs);
`else
    if (bad) cs = 8'h00;
`endif
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       hold;
    logic [7:0] tx;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int a0, w0;
    vecs[0] = '{8'h48, 1'b1, 8'h06};
    vecs[1] = '{8'h41, 1'b1, 8'h15};
    vecs[2] = '{8'h47, 1'b0, 8'h06};
    vecs[3] = '{8'h41, 1'b0, 8'h15};
    vecs[4] = '{8'h00, 1'b0, 8'h15};
    vecs[5] = '{8'h48, 1'b1, 8'h06};
    vecs[6] = '{8'hFF, 1'b1, 8'h15};
    vecs[7] = '{8'h47, 1'b0, 8'h06};

    reset = 1'b1;
    in_rx_valid = 1'b0;
    in_rx_data = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_en",   {31'b0, out_tx_en}, 32'd0);
    check("rst_tx_data", {24'b0, out_tx_data}, 32'd0);
    check("rst_rx_ack",  {31'b0, out_rx_ack}, 32'd0);
    check("rst_mem_we",  {31'b0, out_mem_write_en}, 32'd0);
    check("rst_addr",    out_mem_address, 32'd0);
    check("rst_wdata",   out_mem_write_data, 32'd0);
    check("rst_hold",    {31'b0, out_cpu_hold}, 32'd0);
    check("rst_busy",    {31'b0, out_busy}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Write frame
    a0 = ack_cnt;
    send_frame(8'h57, 32'h10, 32'hDEADBEEF, 1'b0);
    wait_idle();
    check("w_count", wr_cnt, 1);
    check("w_addr", wr_a, 32'h10);
    check("w_data", wr_d, 32'hDEADBEEF);
    check("w_latency", wr_cyc, ack_cyc);
    check("w_acks", ack_cnt - a0, W_ACKS);
    check("w_txn", txq.size(), 1);
    if (txq.size() >= 1) check("w_tx", {24'b0, txq[0]}, 32'h06);
    txq.delete();

    // Read frame
    send_frame(8'h52, 32'h10, 32'h0, 1'b0);
    wait_idle();
    check("r_txn", txq.size(), 4);
    if (txq.size() == 4) begin
      check("r_tx0", {24'b0, txq[0]}, 32'hEF);
      check("r_tx1", {24'b0, txq[1]}, 32'hBE);
      check("r_tx2", {24'b0, txq[2]}, 32'hAD);
      check("r_tx3", {24'b0, txq[3]}, 32'hDE);
    end
    check("r_addr_held", out_mem_address, 32'h10);
    check("r_no_write", wr_cnt, 1);
    txq.delete();

    // Single-byte commands
    for (int i = 0; i < 8; i++) begin
      send_byte(vecs[i].cmd);
      wait_idle();
      check($sformatf("v%0d_txn", i), txq.size(), 1);
      if (txq.size() >= 1)
        check($sformatf("v%0d_tx", i), {24'b0, txq[0]}, {24'b0, vecs[i].tx});
      check($sformatf("v%0d_hold", i), {31'b0, out_cpu_hold},
            {31'b0, vecs[i].hold});
      txq.delete();
    end

    // Inter-byte timeout mid-frame
    w0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h10);
    send_byte(8'h00);
    @(negedge clk);
    check("to_busy_mid", {31'b0, out_busy}, 32'd1);
    repeat (150) @(negedge clk);
    check("to_idle", {31'b0, out_busy}, 32'd0);
    check("to_no_write", wr_cnt, w0);
    check("to_no_tx", txq.size(), 0);
    send_frame(8'h52, 32'h10, 32'h0, 1'b0);
    wait_idle();
    check("to_r_txn", txq.size(), 4);
    if (txq.size() == 4) begin
      check("to_r_tx0", {24'b0, txq[0]}, 32'hEF);
      check("to_r_tx3", {24'b0, txq[3]}, 32'hDE);
    end
    txq.delete();

`ifdef DEBUG_BRIDGE_CHECKSUM_EN
    w0 = wr_cnt;
    send_frame(8'h57, 32'h20, 32'h12345678, 1'b1);
    wait_idle();
    check("cs_bad_nowrite", wr_cnt, w0);
    check("cs_bad_txn", txq.size(), 1);
    if (txq.size() >= 1) check("cs_bad_tx", {24'b0, txq[0]}, 32'h15);
    txq.delete();
    send_frame(8'h57, 32'h20, 32'h12345678, 1'b0);
    wait_idle();
    check("cs_ok_write", wr_cnt, w0 + 1);
    check("cs_ok_data", wr_d, 32'h12345678);
    check("cs_ok_txn", txq.size(), 1);
    if (txq.size() >= 1) check("cs_ok_tx", {24'b0, txq[0]}, 32'h06);
    txq.delete();
`endif

    // Reset during the read response
    send_byte(8'h48);
    wait_idle();
    check("pre_rst_hold", {31'b0, out_cpu_hold}, 32'd1);
    txq.delete();
    send_frame(8'h52, 32'h10, 32'h0, 1'b0);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_out) break;
    end
    check("mid_tx_started", {31'b0, tx_out}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mr_tx_en",   {31'b0, out_tx_en}, 32'd0);
    check("mr_tx_data", {24'b0, out_tx_data}, 32'd0);
    check("mr_mem_we",  {31'b0, out_mem_write_en}, 32'd0);
    check("mr_addr",    out_mem_address, 32'd0);
    check("mr_rx_ack",  {31'b0, out_rx_ack}, 32'd0);
    check("mr_hold",    {31'b0, out_cpu_hold}, 32'd0);
    check("mr_busy",    {31'b0, out_busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    check("tx_order_stable", tx_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
